// File: rtl/traffic_light_pkg.sv
// Phase codes, lamp patterns and monitor state encoding shared by traffic_light_monitor
// and its lamp decoder.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        PH_NSG_EWR   = 3'd0,
        PH_NSY_EWR   = 3'd1,
        PH_NSR_EWR_0 = 3'd2,
        PH_NSR_EWG   = 3'd3,
        PH_NSR_EWY   = 3'd4,
        PH_NSR_EWR_1 = 3'd5,
        PH_NONE      = 3'd7
    } phase_e;

    // Lamp vector bit order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
    localparam logic [5:0] PAT_NSG_EWR = 6'b100_001;
    localparam logic [5:0] PAT_NSY_EWR = 6'b010_001;
    localparam logic [5:0] PAT_NSR_EWG = 6'b001_100;
    localparam logic [5:0] PAT_NSR_EWY = 6'b001_010;
    localparam logic [5:0] PAT_ALL_RED = 6'b001_001;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_NSG_EWR:   return PH_NSY_EWR;
            PH_NSY_EWR:   return PH_NSR_EWR_0;
            PH_NSR_EWR_0: return PH_NSR_EWG;
            PH_NSR_EWG:   return PH_NSR_EWY;
            PH_NSR_EWY:   return PH_NSR_EWR_1;
            PH_NSR_EWR_1: return PH_NSG_EWR;
            default:      return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_monitor_decoder.sv
// tl_lamp_decoder: maps the registered lamp vector and the predecessor phase to a phase
// code plus an illegal-pattern flag.
module tl_lamp_decoder
    import traffic_light_pkg::*;
(
    input  logic [5:0] i_lamps,
    input  phase_e     i_pred,
    output phase_e     o_phase,
    output logic       o_illegal
);

    always_comb begin
        o_phase   = PH_NONE;
        o_illegal = 1'b0;
        case (i_lamps)
            PAT_NSG_EWR: o_phase = PH_NSG_EWR;
            PAT_NSY_EWR: o_phase = PH_NSY_EWR;
            PAT_NSR_EWG: o_phase = PH_NSR_EWG;
            PAT_NSR_EWY: o_phase = PH_NSR_EWY;
            // All-red is the post-EW phase only after the EW half; otherwise post-NS
            PAT_ALL_RED: o_phase = (i_pred == PH_NSR_EWG || i_pred == PH_NSR_EWY ||
                                    i_pred == PH_NSR_EWR_1) ? PH_NSR_EWR_1 : PH_NSR_EWR_0;
            default:     o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive six-phase traffic lamp checker: sequence, pattern and dwell faults plus cycle count.
// Dwell checking is built only when TRAFFIC_MON_DWELL_CHECK_EN is defined.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int unsigned P0_CYC = 4,
    parameter int unsigned P1_CYC = 16,
    parameter int unsigned P2_CYC = 4,
    parameter int unsigned P3_CYC = 4,
    parameter int unsigned P4_CYC = 16,
    parameter int unsigned P5_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ns_g,
    input  logic        ns_y,
    input  logic        ns_r,
    input  logic        ew_g,
    input  logic        ew_y,
    input  logic        ew_r,
    input  logic        clr_fault,
    output logic [2:0]  phase,
    output logic        phase_valid,
    output logic        fault_illegal,
    output logic        fault_seq,
    output logic        fault_dwell,
    output logic        fault,
    output logic        cycle_done,
    output logic [15:0] cycle_count,
    output logic [1:0]  dbg_state
);

    logic [5:0]  r_lamps, r_prev;
    mon_state_e  r_state, w_state_next;
    phase_e      r_phase, w_phase_next, w_dec_phase;
    logic        r_fault_illegal, w_fi_next, r_fault_seq, w_fs_next;
    logic        r_cycle_done, w_done_next;
    logic [15:0] r_cycle_count, w_count_next;
    logic        w_illegal, w_change, w_sync_hit, w_seq_err;

    tl_lamp_decoder u_dec (
        .i_lamps   (r_lamps),
        .i_pred    (r_phase),
        .o_phase   (w_dec_phase),
        .o_illegal (w_illegal)
    );

    assign w_change   = (r_lamps != r_prev);
    assign w_sync_hit = w_change && (r_lamps == PAT_NSG_EWR);
    assign w_seq_err  = w_change && !w_illegal && (w_dec_phase != next_phase(r_phase));

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_fi_next    = r_fault_illegal;
        w_fs_next    = r_fault_seq;
        w_done_next  = 1'b0;
        w_count_next = r_cycle_count;
        if (clr_fault) begin
            w_state_next = SYNC;
            w_phase_next = PH_NONE;
            w_fi_next    = 1'b0;
            w_fs_next    = 1'b0;
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_illegal) begin
                        w_fi_next    = 1'b1;
                        w_state_next = FAULT;
                    end else if (w_sync_hit) begin
                        w_state_next = TRACK;
                        w_phase_next = PH_NSG_EWR;
                    end
                end
                TRACK: begin
                    if (w_illegal || w_seq_err) begin
                        w_fi_next    = r_fault_illegal | w_illegal;
                        w_fs_next    = r_fault_seq | w_seq_err;
                        w_state_next = FAULT;
                        w_phase_next = PH_NONE;
                    end else if (w_change) begin
                        w_phase_next = w_dec_phase;
                        if (r_phase == PH_NSR_EWR_1) begin
                            w_done_next  = 1'b1;
                            w_count_next = (r_cycle_count == 16'hFFFF) ? r_cycle_count
                                                                       : r_cycle_count + 16'd1;
                        end
                    end
                end
                FAULT:   ;
                default: w_state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lamps         <= PAT_ALL_RED;
            r_prev          <= PAT_ALL_RED;
            r_state         <= SYNC;
            r_phase         <= PH_NONE;
            r_fault_illegal <= 1'b0;
            r_fault_seq     <= 1'b0;
            r_cycle_done    <= 1'b0;
            r_cycle_count   <= 16'd0;
        end else begin
            r_lamps         <= {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
            r_prev          <= r_lamps;
            r_state         <= w_state_next;
            r_phase         <= w_phase_next;
            r_fault_illegal <= w_fi_next;
            r_fault_seq     <= w_fs_next;
            r_cycle_done    <= w_done_next;
            r_cycle_count   <= w_count_next;
        end
    end

`ifdef TRAFFIC_MON_DWELL_CHECK_EN
    logic [7:0] r_dwell, w_dwell_next, w_dwell_inc, w_limit;
    logic       r_first, w_first_next, r_fault_dwell, w_fd_next;

    assign w_dwell_inc = (r_dwell == 8'hFF) ? r_dwell : r_dwell + 8'd1;

    always_comb begin
        case (r_phase)
            PH_NSG_EWR:   w_limit = 8'(P0_CYC);
            PH_NSY_EWR:   w_limit = 8'(P1_CYC);
            PH_NSR_EWR_0: w_limit = 8'(P2_CYC);
            PH_NSR_EWG:   w_limit = 8'(P3_CYC);
            PH_NSR_EWY:   w_limit = 8'(P4_CYC);
            PH_NSR_EWR_1: w_limit = 8'(P5_CYC);
            default:      w_limit = 8'hFF;
        endcase
    end

    // r_first masks the phase in progress at reset, whose true start was never seen
    always_comb begin
        w_dwell_next = r_dwell;
        w_first_next = r_first;
        w_fd_next    = r_fault_dwell;
        if (clr_fault) begin
            w_dwell_next = 8'd0;
            w_fd_next    = 1'b0;
        end else if (r_state == SYNC) begin
            if (!w_illegal && w_sync_hit)
                w_dwell_next = 8'd1;
        end else if (r_state == TRACK && !w_illegal) begin
            if (w_change) begin
                w_first_next = 1'b0;
                if (!r_first && r_dwell != w_limit)
                    w_fd_next = 1'b1;
                if (!w_seq_err)
                    w_dwell_next = 8'd1;
            end else begin
                w_dwell_next = w_dwell_inc;
                if (!r_first && w_dwell_inc > w_limit)
                    w_fd_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dwell       <= 8'd0;
            r_first       <= 1'b1;
            r_fault_dwell <= 1'b0;
        end else begin
            r_dwell       <= w_dwell_next;
            r_first       <= w_first_next;
            r_fault_dwell <= w_fd_next;
        end
    end

    assign fault_dwell = r_fault_dwell;
`else
    assign fault_dwell = 1'b0;
`endif

    assign phase         = r_phase;
    assign phase_valid   = (r_state == TRACK);
    assign fault_illegal = r_fault_illegal;
    assign fault_seq     = r_fault_seq;
    assign fault         = r_fault_illegal | r_fault_seq | fault_dwell;
    assign cycle_done    = r_cycle_done;
    assign cycle_count   = r_cycle_count;
    assign dbg_state     = r_state;

endmodule
